branch_predictor: RTL and testbench

//  Fetch-side counterpart of EX-stage branch resolution in the RV32IM pipeline.

---
 rtl/bp_pkg.sv | 21 ++
 rtl/branch_predictor_if.sv | 43 ++++
 rtl/bp_sat_counter.sv | 20 ++
 rtl/branch_predictor.sv | 96 +++++++++
 tb/tb_branch_predictor.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Shared counter encodings and constants for the branch predictor.
// Counter meaning: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
package bp_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  // A newly allocated entry starts weakly taken, so it predicts taken on its first hit.
  localparam ctr_t CTR_INIT_ALLOC = CTR_WT;

  localparam logic [31:0] RESET_PC_INC = 32'd4;

  function automatic logic ctr_predicts_taken(input ctr_t c);
    return c[1];
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup and EX resolution signals between the pipeline and the predictor.
// Master is the pipeline side; slave is the predictor.
interface branch_predictor_if;

  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;

  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;

  modport master (
    output fetch_pc,
    input  pred_taken,
    input  pred_target,
    output upd_valid,
    output upd_pc,
    output upd_taken,
    output upd_target,
    output upd_pred_taken,
    output upd_pred_target,
    input  mispredict
  );

  modport slave (
    input  fetch_pc,
    output pred_taken,
    output pred_target,
    input  upd_valid,
    input  upd_pc,
    input  upd_taken,
    input  upd_target,
    input  upd_pred_taken,
    input  upd_pred_target,
    output mispredict
  );

endinterface

// File: rtl/bp_sat_counter.sv
// 2-bit saturating counter next-state: step toward taken or not-taken, clamp at the ends.
// Purely combinational, no backpressure.
module bp_sat_counter
  import bp_pkg::*;
(
  input  ctr_t cur,
  input  logic taken,
  output ctr_t nxt
);

  always_comb begin
    nxt = cur;
    if (taken) begin
      if (cur != CTR_ST) nxt = cur + 2'd1;
    end else begin
      if (cur != CTR_SNT) nxt = cur - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB + 2-bit counters: zero-latency lookup, updates visible next cycle, no stalls.
// Optional BP_STATS_EN adds branch and mispredict counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 64
) (
  input  logic clk,
  input  logic reset,
  branch_predictor_if.slave bp
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispred
`endif
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int TAG_BITS = 30 - IDX_BITS;

  typedef logic [IDX_BITS-1:0] idx_t;
  typedef logic [TAG_BITS-1:0] tag_t;

  logic [ENTRIES-1:0] valid;
  tag_t               tag_mem [ENTRIES];
  logic [31:0]        tgt_mem [ENTRIES];
  ctr_t               ctr_mem [ENTRIES];

  // Lookup side
  idx_t fidx;
  tag_t ftag;
  logic fhit;

  assign fidx = bp.fetch_pc[IDX_BITS+1:2];
  assign ftag = bp.fetch_pc[31:IDX_BITS+2];
  assign fhit = valid[fidx] && (tag_mem[fidx] == ftag);

  assign bp.pred_taken  = fhit && ctr_predicts_taken(ctr_mem[fidx]);
  assign bp.pred_target = bp.pred_taken ? tgt_mem[fidx] : bp.fetch_pc + RESET_PC_INC;

  // Update side
  idx_t uidx;
  tag_t utag;
  logic uhit;
  logic upd_en;
  ctr_t ctr_nxt;

  assign uidx   = bp.upd_pc[IDX_BITS+1:2];
  assign utag   = bp.upd_pc[31:IDX_BITS+2];
  assign uhit   = valid[uidx] && (tag_mem[uidx] == utag);
  assign upd_en = bp.upd_valid && !reset;

  // Instruction-aligned PCs: the byte-offset bits carry no information here.
  logic unused_upd_pc_lsb;
  assign unused_upd_pc_lsb = ^bp.upd_pc[1:0];

  bp_sat_counter u_sat_counter (
    .cur   (ctr_mem[uidx]),
    .taken (bp.upd_taken),
    .nxt   (ctr_nxt)
  );

  assign bp.mispredict = upd_en &&
                         ((bp.upd_taken != bp.upd_pred_taken) ||
                          (bp.upd_taken && (bp.upd_target != bp.upd_pred_target)));

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
    end else if (upd_en && !uhit && bp.upd_taken) begin
      valid[uidx] <= 1'b1;
    end
  end

  // Entry payload has no reset; valid alone gates its use. Not-taken misses never allocate.
  always_ff @(posedge clk) begin
    if (upd_en && (uhit || bp.upd_taken)) begin
      tag_mem[uidx] <= utag;
      ctr_mem[uidx] <= uhit ? ctr_nxt : CTR_INIT_ALLOC;
      if (bp.upd_taken) tgt_mem[uidx] <= bp.upd_target;
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else begin
      if (upd_en)        stat_branches <= stat_branches + 32'd1;
      if (bp.mispredict) stat_mispred  <= stat_mispred + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboarded random/directed bench for branch_predictor against an arithmetic reference model.
module tb_branch_predictor;

  localparam int ENTRIES = 64;
  localparam int IDXB    = $clog2(ENTRIES);

  logic clk;
  logic rst;

  branch_predictor_if bp ();

`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;
`endif

  branch_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk   (clk),
    .reset (rst),
    .bp    (bp)
`ifdef BP_STATS_EN
    ,
    .stat_branches (stat_branches),
    .stat_mispred  (stat_mispred)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          lk;
    logic        pt;
    logic [31:0] ptgt;
    logic        mp;
    logic [31:0] sb;
    logic [31:0] sm;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int n_chk  = 0;
  int n_pass = 0;
  int cyc_no = 0;

  // Reference model: one slot per index holding owning PC-tag, target and a strength 0..3.
  bit          m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_str   [ENTRIES];
  int unsigned m_nbr = 0;
  int unsigned m_nmp = 0;

  function automatic int midx(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic logic [31:0] mtag(input logic [31:0] pc);
    return pc >> (2 + IDXB);
  endfunction

  function automatic void mlook(input logic [31:0] pc, output logic t, output logic [31:0] tg);
    int i;
    bit hit;
    i   = midx(pc);
    hit = m_valid[i] && (m_tag[i] == mtag(pc));
    t   = hit && (m_str[i] >= 2);
    tg  = t ? m_tgt[i] : pc + 32'd4;
  endfunction

  task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
  endtask

  task automatic cycle(input bit r, input logic [31:0] fpc, input bit uv, input logic [31:0] upc,
                       input bit ut, input logic [31:0] utgt, input bit upt,
                       input logic [31:0] uptgt, input bit lk);
    exp_t e;
    int   i;
    bit   hit;
    @(posedge clk);
    #1;
    rst                = r;
    bp.fetch_pc        = fpc;
    bp.upd_valid       = uv;
    bp.upd_pc          = upc;
    bp.upd_taken       = ut;
    bp.upd_target      = utgt;
    bp.upd_pred_taken  = upt;
    bp.upd_pred_target = uptgt;
    cyc_no++;
    e.lk  = lk;
    e.cyc = cyc_no;
    mlook(fpc, e.pt, e.ptgt);
    e.mp = uv && !r && ((ut != upt) || (ut && (utgt != uptgt)));
    e.sb = m_nbr;
    e.sm = m_nmp;
    q.push_back(e);
    if (r) begin
      for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
      m_nbr = 0;
      m_nmp = 0;
    end else if (uv) begin
      m_nbr++;
      if (e.mp) m_nmp++;
      i   = midx(upc);
      hit = m_valid[i] && (m_tag[i] == mtag(upc));
      if (hit) begin
        m_str[i] = ut ? ((m_str[i] < 3) ? m_str[i] + 1 : 3) : ((m_str[i] > 0) ? m_str[i] - 1 : 0);
        if (ut) m_tgt[i] = utgt;
      end else if (ut) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = mtag(upc);
        m_tgt[i]   = utgt;
        m_str[i]   = 2;
      end
    end
  endtask

  task automatic look(input logic [31:0] fpc);
    cycle(0, fpc, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
  endtask

  task automatic upd(input logic [31:0] fpc, input logic [31:0] upc, input bit ut,
                     input logic [31:0] utgt, input bit upt, input logic [31:0] uptgt);
    cycle(0, fpc, 1, upc, ut, utgt, upt, uptgt, 1);
  endtask

  function automatic logic [31:0] pool_pc();
    return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 2) |
           32'($urandom_range(0, 3));
  endfunction

  // Monitor: the predictor's outputs are always presented; one expectation per cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("mispredict", e.cyc, 32'(bp.mispredict), 32'(e.mp));
        if (e.lk) begin
          chk("pred_taken", e.cyc, 32'(bp.pred_taken), 32'(e.pt));
          chk("pred_target", e.cyc, bp.pred_target, e.ptgt);
`ifdef BP_STATS_EN
          chk("stat_branches", e.cyc, stat_branches, e.sb);
          chk("stat_mispred", e.cyc, stat_mispred, e.sm);
`endif
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fpc, upc, utgt, uptgt;
    logic        upt, mt;
    logic [31:0] mtg;
    bit          ut, uv, r;
    int          waits;

    rst = 1'b1;
    bp.fetch_pc = 32'h0; bp.upd_valid = 1'b0; bp.upd_pc = 32'h0; bp.upd_taken = 1'b0;
    bp.upd_target = 32'h0; bp.upd_pred_taken = 1'b0; bp.upd_pred_target = 32'h0;

    // Reset with an update pending: dropped, no mispredict; lookup state unknown until cleared.
    cycle(1, 32'h100, 1, 32'h300, 1, 32'h500, 0, 32'h304, 0);
    cycle(1, 32'h100, 1, 32'h300, 1, 32'h500, 0, 32'h304, 1);
    look(32'h100);
    look(32'h300);
    // First taken resolution: mispredict and allocate.
    upd(32'h100, 32'h100, 1, 32'h80, 0, 32'h104);
    look(32'h100);
    // Saturate, then decay one step (still taken), then another (not taken).
    upd(32'h100, 32'h100, 1, 32'h80, 1, 32'h80);
    upd(32'h100, 32'h100, 1, 32'h80, 1, 32'h80);
    upd(32'h100, 32'h100, 1, 32'h80, 1, 32'h80);
    upd(32'h100, 32'h100, 0, 32'h80, 1, 32'h80);
    look(32'h100);
    upd(32'h100, 32'h100, 0, 32'h80, 1, 32'h80);
    look(32'h100);
    // Restore to taken, then alias with 0x200 at the same index.
    upd(32'h100, 32'h100, 1, 32'h80, 0, 32'h104);
    upd(32'h100, 32'h200, 1, 32'h40, 0, 32'h204);
    look(32'h100);
    look(32'h200);
    // Same-cycle update and lookup of one index: old contents first, new contents next cycle.
    upd(32'h100, 32'h100, 1, 32'h900, 0, 32'h104);
    look(32'h100);
    look(32'h103);
    look(32'hFFFF_FFFC);
    // Mid-run reset with a taken update on a fresh PC: dropped.
    cycle(1, 32'h100, 1, 32'h600, 1, 32'h700, 0, 32'h604, 1);
    look(32'h600);
    look(32'h100);

    for (int n = 0; n < 500; n++) begin
      fpc = ($urandom_range(0, 9) < 7) ? pool_pc() :
            (($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFC : 32'($urandom));
      upc  = ($urandom_range(0, 9) < 8) ? pool_pc() : 32'($urandom);
      uv   = ($urandom_range(0, 3) != 0);
      ut   = ($urandom_range(0, 1) == 1);
      utgt = 32'($urandom) & 32'hFFFF_FFFC;
      if ($urandom_range(0, 1) == 0) begin
        mlook(upc, mt, mtg);
        upt   = mt;
        uptgt = mtg;
      end else begin
        upt   = 1'($urandom_range(0, 1));
        uptgt = ($urandom_range(0, 1) == 0) ? utgt : 32'($urandom);
      end
      r = ($urandom_range(0, 59) == 0);
      cycle(r, fpc, uv, upc, ut, utgt, upt, uptgt, 1);
    end

    waits = 0;
    while (q.size() > 0 && waits < 10) begin
      @(negedge clk);
      waits++;
    end
    #1;
    if (q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
